// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state type and constants for the iterative multiply/divide unit
package multdiv_pkg;
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;
    localparam int DEF_WIDTH = 32;
    localparam logic [DEF_WIDTH-1:0] MIN_INT = 32'h8000_0000;
    localparam int ITERS = DEF_WIDTH;
endpackage

// File: rtl/twos_negate.sv
// twos_negate: conditional two's-complement negation
module twos_negate #(
    parameter int W = 32
) (
    input  logic         en_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);
    assign y_o = en_i ? -a_i : a_i;
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (shift-add) / divide (restoring), one bit per cycle
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d, res_q, res_d;
    logic               neg_q, neg_d, exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
    logic [WIDTH-1:0]   abs_a, abs_b, rem_sh;
    logic [2*WIDTH-1:0] fix_in, fixed;
    logic [WIDTH:0]     add_s, sub_s;
    logic               accept, last, running;

    twos_negate #(.W(WIDTH)) u_abs_a (.en_i(operandA[WIDTH-1]), .a_i(operandA), .y_o(abs_a));
    twos_negate #(.W(WIDTH)) u_abs_b (.en_i(operandB[WIDTH-1]), .a_i(operandB), .y_o(abs_b));
    // Full-width fix-up so the multiply overflow test sees the signed 64-bit product
    twos_negate #(.W(2*WIDTH)) u_fix (.en_i(neg_q), .a_i(fix_in), .y_o(fixed));

    assign accept  = (state_q == IDLE || state_q == DONE) && (ctrl_MULT || ctrl_DIV);
    assign running = state_q == MULT || state_q == DIV;
    assign last    = cnt_q == CNT_W'(WIDTH);
    assign add_s   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, p_q[0] ? m_q : '0};
    assign rem_sh  = p_q[2*WIDTH-2:WIDTH-1];
    assign sub_s   = {1'b0, rem_sh} - {1'b0, m_q};
    assign fix_in  = state_q == MULT ? p_q : {{WIDTH{1'b0}}, p_q[WIDTH-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        neg_d   = neg_q;
        res_d   = res_q;
        exc_d   = exc_q;
        rdy_d   = 1'b0;
        busy_d  = busy_q;
        if (accept) begin
            // p holds the multiplier (mult) or dividend (div); m holds the other operand
            state_d = ctrl_MULT ? MULT : DIV;
            cnt_d   = '0;
            p_d     = {{WIDTH{1'b0}}, ctrl_MULT ? abs_b : abs_a};
            m_d     = ctrl_MULT ? abs_a : abs_b;
            neg_d   = operandA[WIDTH-1] ^ operandB[WIDTH-1];
            exc_d   = 1'b0;
            busy_d  = 1'b1;
        end else if (state_q == DIV && m_q == '0) begin
            state_d = DONE;
            res_d   = '0;
            exc_d   = 1'b1;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (running && last) begin
            state_d = DONE;
            res_d   = fixed[WIDTH-1:0];
            exc_d   = state_q == MULT ? fixed[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){fixed[WIDTH-1]}}
                                      : !neg_q && p_q[WIDTH-1];
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (running) begin
            cnt_d = cnt_q + 1'b1;
            p_d   = state_q == MULT ? {add_s, p_q[WIDTH-1:1]}
                  : sub_s[WIDTH] ? {rem_sh, p_q[WIDTH-2:0], 1'b0}
                  : {sub_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: vector table, corner sequences and random ops checked against an arithmetic model
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic        clock = 1'b0, reset = 1'b1, ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
    logic [31:0] operandA = '0, operandB = '0;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;
    int          checks = 0, failures = 0;
    logic [31:0] prev_res = '0;

    always #5 clock = ~clock;

    multdiv_unit dut (
        .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .operandA(operandA), .operandB(operandB), .data_result(data_result),
        .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
    );

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic void model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        longint p;
        lat = ITERS + 1;
        if (m) p = longint'($signed(a)) * longint'($signed(b));
        else if (b == 0) begin
            p = 0;
            lat = 1;
        end else p = longint'($signed(a)) / longint'($signed(b));
        r = p[31:0];
        e = (!m && b == 0) || p != longint'($signed(r));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_INT;
            3: return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        operandA  = a;
        operandB  = b;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clock);
            if (data_resultRDY) lat = k;
        end
    endtask

    task automatic run_vec(input string tag, input logic m, input logic d, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic ee, input int el);
        int lat;
        start_op(m, d, a, b);
        check({tag, " busy_start"}, 64'(busy), 64'(1));
        check({tag, " rdy_start"}, 64'(data_resultRDY), 64'(0));
        check({tag, " exc_cleared"}, 64'(data_exception), 64'(0));
        check({tag, " res_held"}, 64'(data_result), 64'(prev_res));
        wait_rdy(lat);
        check({tag, " latency"}, 64'(lat), 64'(el));
        check({tag, " result"}, 64'(data_result), 64'(er));
        check({tag, " exception"}, 64'(data_exception), 64'(ee));
        check({tag, " busy_done"}, 64'(busy), 64'(0));
        @(negedge clock);
        check({tag, " rdy_pulse_end"}, 64'(data_resultRDY), 64'(0));
        check({tag, " result_hold"}, 64'(data_result), 64'(er));
        prev_res = er;
    endtask

    initial begin
        vec_t        vecs[12];
        int          lat;
        logic        seen, m, e;
        logic [31:0] a, b, r;

        vecs[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 33};
        vecs[1]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0,        1'b1, 33};
        vecs[2]  = '{1'b1, 1'b0, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0, 33};
        vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 33};
        vecs[4]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'h0,         1'b1, 1};
        vecs[5]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
        vecs[6]  = '{1'b1, 1'b1, 32'd3,        32'd5,        32'd15,        1'b0, 33};
        vecs[7]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        1'b0, 33};
        vecs[8]  = '{1'b0, 1'b1, 32'd3,        32'd7,        32'd0,         1'b0, 33};
        vecs[9]  = '{1'b0, 1'b1, 32'd7,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 33};
        vecs[10] = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2,        32'hFFFF_FFFE, 1'b1, 33};
        vecs[11] = '{1'b0, 1'b1, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0, 33};

        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset result", 64'(data_result), 64'(0));
        check("reset exception", 64'(data_exception), 64'(0));
        check("reset rdy", 64'(data_resultRDY), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        reset = 1'b1;

        for (int i = 0; i < 12; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].exc, vecs[i].lat);

        // Mid-flight divide-by-zero start must be ignored by a running multiply
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            if (k == 10) begin
                ctrl_DIV = 1'b1;
                operandA = 32'd100;
                operandB = 32'd0;
            end
            @(negedge clock);
            ctrl_DIV = 1'b0;
            if (data_resultRDY) lat = k;
        end
        check("ignore latency", 64'(lat), 64'(33));
        check("ignore result", 64'(data_result), 64'(12));
        check("ignore exception", 64'(data_exception), 64'(0));
        prev_res = 32'd12;
        @(negedge clock);

        // Reset during a divide abandons it
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (14) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midreset result", 64'(data_result), 64'(0));
        check("midreset exception", 64'(data_exception), 64'(0));
        check("midreset rdy", 64'(data_resultRDY), 64'(0));
        check("midreset busy", 64'(busy), 64'(0));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY || busy) seen = 1'b1;
        end
        check("midreset no_rdy", 64'(seen), 64'(0));
        prev_res = '0;
        run_vec("post_reset_mult", 1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, 33);

        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            model(m, a, b, r, e, lat);
            run_vec($sformatf("rand%0d %s %0h %0h", i, m ? "mul" : "div", a, b), m, !m, a, b, r, e, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
